// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   XLEN      operand/result width (only 32 is supported)
//   ITER      number of radix-2 steps per operation
//   CNT_W     width of the iteration counter
//   op_e      funct3 operation encoding
//   state_e   control FSM states
// Small helpers decode operation class and operand signedness from op_e.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = 6;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // Division class: DIV, DIVU, REM, REMU.
   function automatic logic is_div(input op_e op);
      return op[2];
   endfunction

   // Remainder class: REM, REMU.
   function automatic logic is_rem(input op_e op);
      return op[2] & op[1];
   endfunction

   // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
   // MUL only returns the low half, which is identical either way.
   function automatic logic a_is_signed(input op_e op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as signed for MUL, MULH, DIV and REM.
   function automatic logic b_is_signed(input op_e op);
      return (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage : muldiv_pkg

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. One radix-2 step per cycle on a
// shared 64-bit accumulator, followed by a single sign-fix cycle.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   start     request an operation (only looked at in IDLE)
//   funct3    operation select (see muldiv_pkg::op_e)
//   dataA     rs1 operand
//   dataB     rs2 operand
//   rd        destination register index
//   kill      abort the in-flight operation
//   busy      high from the cycle after acceptance until done, inclusive
//   done      single-cycle completion pulse
//   WB_out    result, qualified by done
//   addD      captured rd, qualified by done
//   RegWrite  done and captured rd is non-zero
//
// Handshake: an operation is accepted on a rising edge where the unit is
// IDLE, start=1 and kill=0. There is no backpressure on the result side:
// done is a one-cycle pulse and WB_out/addD must be consumed in that cycle.
// While busy=1 start is ignored (not queued).
//
// Timing: accepted at edge 0 -> CALC cycles 1..32 -> FIX cycle 33 ->
// DONE cycle 34. Divide-by-zero and signed overflow skip straight to DONE
// at cycle 1.
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] dataA,
   input  logic [XLEN-1:0] dataB,
   input  logic [4:0]      rd,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] WB_out,
   output logic [4:0]      addD,
   output logic            RegWrite
);

   import muldiv_pkg::*;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);
   localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   state_e              state;        // observable FSM state for checkers
   state_e              state_next;
   op_e                 op_q;
   logic [2*XLEN-1:0]   acc;          // {high, low} for mul, {rem, quot} for div
   logic [XLEN-1:0]     opb_q;        // magnitude of rs2
   logic [CNT_W-1:0]    cnt;
   logic                neg_q;        // result needs negation in FIX
   logic [4:0]          rd_q;

   // ---------------------------------------------------------------------
   // Input decode at acceptance
   // ---------------------------------------------------------------------
   op_e                 op_in;
   logic                accept;
   logic                sign_a;
   logic                sign_b;
   logic [XLEN-1:0]     mag_a;
   logic [XLEN-1:0]     mag_b;
   logic                neg_in;
   logic                div_zero;
   logic                div_ovf;
   logic                special;
   logic [XLEN-1:0]     special_res;

   always_comb begin
      op_in       = op_e'(funct3);
      accept      = (state == ST_IDLE) && start && !kill;
      sign_a      = a_is_signed(op_in) & dataA[XLEN-1];
      sign_b      = b_is_signed(op_in) & dataB[XLEN-1];
      // Two's-complement negation of MIN_NEG yields MIN_NEG, which read as
      // unsigned is exactly the required magnitude 2^(XLEN-1).
      mag_a       = sign_a ? (~dataA + 1'b1) : dataA;
      mag_b       = sign_b ? (~dataB + 1'b1) : dataB;

      // Remainder follows the dividend; everything else follows the XOR.
      if (is_rem(op_in)) begin
         neg_in = sign_a;
      end else begin
         neg_in = sign_a ^ sign_b;
      end

      div_zero    = is_div(op_in) && (dataB == '0);
      div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (dataA == MIN_NEG) && (dataB == ALL_ONES);
      special     = div_zero || div_ovf;

      special_res = '0;
      if (div_zero) begin
         special_res = is_rem(op_in) ? dataA : ALL_ONES;
      end else if (div_ovf) begin
         special_res = is_rem(op_in) ? '0 : MIN_NEG;
      end
   end

   // ---------------------------------------------------------------------
   // One radix-2 step on the shared accumulator
   // ---------------------------------------------------------------------
   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       div_top;
   logic [XLEN:0]       div_diff;
   logic                div_fit;
   logic [2*XLEN-1:0]   step_next;

   always_comb begin
      // Shift-add: conditionally add the multiplicand into the high half,
      // then shift the whole 65-bit {carry, acc} right by one.
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);

      // Restoring division: shift left by one and try to subtract the
      // divisor from the partial remainder. The partial remainder is always
      // below the divisor, so after the shift it fits in XLEN+1 bits.
      div_top  = acc[2*XLEN-1:XLEN-1];
      div_diff = div_top - {1'b0, opb_q};
      div_fit  = (div_top >= {1'b0, opb_q});

      if (is_div(op_q)) begin
         if (div_fit) begin
            step_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end else begin
            step_next = {acc[2*XLEN-2:0], 1'b0};
         end
      end else begin
         step_next = {mul_sum, acc[XLEN-1:1]};
      end
   end

   // ---------------------------------------------------------------------
   // Sign correction and high/low select
   // ---------------------------------------------------------------------
   logic [2*XLEN-1:0]   prod_fixed;
   logic [XLEN-1:0]     quot_mag;
   logic [XLEN-1:0]     rem_mag;
   logic [XLEN-1:0]     fix_res;

   always_comb begin
      prod_fixed = neg_q ? (~acc + 1'b1) : acc;
      quot_mag   = acc[XLEN-1:0];
      rem_mag    = acc[2*XLEN-1:XLEN];
      fix_res    = '0;
      unique case (op_q)
         OP_MUL:                       fix_res = prod_fixed[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fixed[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_res = neg_q ? (~quot_mag + 1'b1) : quot_mag;
         OP_REM, OP_REMU:              fix_res = neg_q ? (~rem_mag + 1'b1) : rem_mag;
         default:                      fix_res = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      if (kill) begin
         state_next = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state_next = special ? ST_DONE : ST_CALC;
               end
            end
            ST_CALC: begin
               if (cnt == LAST_STEP) begin
                  state_next = ST_FIX;
               end
            end
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      busy     = (state != ST_IDLE);
      // A flush arriving in the DONE cycle suppresses the completion pulse,
      // so a killed operation never writes back.
      done     = (state == ST_DONE) && !kill;
      RegWrite = done && (addD != 5'd0);
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_MUL;
         acc    <= '0;
         opb_q  <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         rd_q   <= '0;
         WB_out <= '0;
         addD   <= '0;
      end else if (!kill) begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q  <= op_in;
                  opb_q <= mag_b;
                  neg_q <= neg_in;
                  rd_q  <= rd;
                  cnt   <= '0;
                  // Both mul and div start with |rs1| in the low half.
                  acc   <= {{XLEN{1'b0}}, mag_a};
                  if (special) begin
                     WB_out <= special_res;
                     addD   <= rd;
                  end
               end
            end
            ST_CALC: begin
               acc <= step_next;
               cnt <= cnt + 1'b1;
            end
            ST_FIX: begin
               WB_out <= fix_res;
               addD   <= rd_q;
            end
            ST_DONE: begin
               // Result registers hold until the next completion.
            end
            default: begin
            end
         endcase
      end
   end

endmodule : muldiv_unit
